// File: rtl/weight_stream_bram.sv
// Weight memory with a sequential load port and a
// programmable streaming read port toward one MAC.
module weight_stream_bram #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 28,
  parameter int    ADDR_W    = 5,
  parameter string INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_EN,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_DROP,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic [DATA_W-1:0] DO,
  output logic              DO_VALID,
  input  logic              DO_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W:0] ONE_X =
    (ADDR_W+1)'(1);

  (* ram_style = "block" *)
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   issue_cnt_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] do_q, skid_q;
  logic              do_v_q, skid_v_q;
  logic [ADDR_W-1:0] ld_ptr_q;
  logic              done_q, ld_drop_q;

  logic              busy, hs, last_hs;
  logic              issue, ld_wr;
  logic [1:0]        occ;
  logic [ADDR_W:0]   sa_ext;
  logic [ADDR_W-1:0] start_mod;
  logic [ADDR_W:0]   eff_len;

  // Handshake, occupancy and start-parameter reduction.
  always_comb begin
    busy    = (state_q != IDLE);
    hs      = do_v_q && DO_READY;
    last_hs = hs && !rd_valid_q && !skid_v_q;
    ld_wr   = LD_EN && !busy;
    occ     = 2'(rd_valid_q) + 2'(do_v_q)
            + 2'(skid_v_q) - 2'(hs);
    sa_ext  = {1'b0, START_ADDR};
    start_mod = START_ADDR;
    if (sa_ext >= DEPTH_X)
      start_mod = ADDR_W'(sa_ext - DEPTH_X);
    eff_len = LEN;
    if (LEN == '0 || LEN > DEPTH_X)
      eff_len = DEPTH_X;
  end

  // Next-state and read-issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) state_d = STREAM;
      end
      STREAM: begin
        issue = (issue_cnt_q != '0) && (occ < 2'd2);
        if (issue && issue_cnt_q == ONE_X)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Block RAM: one write port, one registered read port.
  always_ff @(posedge CLK) begin
    if (ld_wr) mem[ld_ptr_q] <= LD_DATA;
    if (issue) rd_data_q <= mem[rd_addr_q];
  end

  // Address/count tracking, load pointer and pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      ld_ptr_q    <= '0;
      done_q      <= 1'b0;
      ld_drop_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && START) begin
        rd_addr_q   <= start_mod;
        issue_cnt_q <= eff_len;
      end else if (issue) begin
        rd_addr_q   <= (rd_addr_q == LAST_A) ?
                       '0 : rd_addr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q - 1'b1;
      end
      rd_valid_q <= issue;
      if (ld_wr)
        ld_ptr_q <= (ld_ptr_q == LAST_A) ?
                    '0 : ld_ptr_q + 1'b1;
      ld_drop_q <= LD_EN && busy;
      done_q    <= (state_q == DRAIN) && last_hs;
    end
  end

  // Output register plus skid entry; refill in order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      do_q     <= '0;
      do_v_q   <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else if (!do_v_q || hs) begin
      if (skid_v_q) begin
        do_q     <= skid_q;
        do_v_q   <= 1'b1;
        skid_v_q <= rd_valid_q;
        if (rd_valid_q) skid_q <= rd_data_q;
      end else begin
        do_v_q <= rd_valid_q;
        if (rd_valid_q) do_q <= rd_data_q;
      end
    end else if (rd_valid_q) begin
      skid_q   <= rd_data_q;
      skid_v_q <= 1'b1;
    end
  end

  assign DO       = do_q;
  assign DO_VALID = do_v_q;
  assign BUSY     = busy;
  assign DONE     = done_q;
  assign LD_DROP  = ld_drop_q;

endmodule

// File: tb/tb_weight_stream_bram.sv
// Bench for weight_stream_bram: array model of the
// weight memory, queue of expected stream words.
module tb_weight_stream_bram;

  localparam int DW = 16;
  localparam int DEPTH = 28;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          LD_EN = 1'b0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_DROP;
  logic          START = 1'b0;
  logic [AW-1:0] START_ADDR = '0;
  logic [AW:0]   LEN = '0;
  logic [DW-1:0] DO;
  logic          DO_VALID;
  logic          DO_READY = 1'b0;
  logic          BUSY;
  logic          DONE;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] mem_m [DEPTH];
  int ptr_m = 0;

  weight_stream_bram #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .LD_EN(LD_EN), .LD_DATA(LD_DATA),
    .LD_DROP(LD_DROP),
    .START(START), .START_ADDR(START_ADDR),
    .LEN(LEN),
    .DO(DO), .DO_VALID(DO_VALID),
    .DO_READY(DO_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    LD_EN = 1'b1;
    LD_DATA = d;
    mem_m[ptr_m] = d;
    ptr_m = (ptr_m + 1) % DEPTH;
    tick();
    LD_EN = 1'b0;
  endtask

  // mode: 0 ready high, 1 pattern 100101, 2 random
  task automatic run_stream(
    input logic [AW-1:0] sa, input logic [AW:0] len,
    input int mode, input int ld_at, input int st_at,
    input bit ld_same, input logic [DW-1:0] ld_val,
    input bit chk_tp);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev;
    logic [5:0] pat;
    int eff, base, cyc, acc;
    bit stall;
    pat = 6'b101001;
    if (ld_same) begin
      LD_EN = 1'b1;
      LD_DATA = ld_val;
      mem_m[ptr_m] = ld_val;
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    eff = (len == 0 || int'(len) > DEPTH) ?
          DEPTH : int'(len);
    base = (int'(sa) >= DEPTH) ?
           int'(sa) - DEPTH : int'(sa);
    for (int i = 0; i < eff; i++)
      exp_q.push_back(mem_m[(base + i) % DEPTH]);
    START = 1'b1;
    START_ADDR = sa;
    LEN = len;
    tick();
    START = 1'b0;
    LD_EN = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: busy=%b done=%b need 1 0",
               BUSY, DONE);
    end
    cyc = 0;
    acc = 0;
    stall = 0;
    prev = '0;
    while (cyc < 400) begin
      if (cyc == 1) begin
        n_checks++;
        if (DO_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid: got %b need 0",
                   DO_VALID);
        end
      end
      if (cyc >= 2 && (cyc == 2 || chk_tp)) begin
        n_checks++;
        if (DO_VALID !== 1'b1) begin
          n_fail++;
          $display("FAIL valid_cyc%0d: got %b need 1",
                   cyc, DO_VALID);
        end
      end
      if (stall) begin
        n_checks++;
        if (DO_VALID !== 1'b1 || DO !== prev) begin
          n_fail++;
          $display("FAIL hold: v=%b do=%h need 1 %h",
                   DO_VALID, DO, prev);
        end
      end
      n_checks++;
      if (LD_DROP !== (ld_at >= 0 && cyc == ld_at + 1)) begin
        n_fail++;
        $display("FAIL ld_drop cyc%0d: got %b", cyc, LD_DROP);
      end
      n_checks++;
      if (DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL early_done cyc%0d: got 1 need 0", cyc);
      end
      LD_EN = (cyc == ld_at);
      LD_DATA = DW'($urandom);
      START = (cyc == st_at);
      START_ADDR = AW'($urandom);
      LEN = (AW+1)'($urandom);
      case (mode)
        0: DO_READY = 1'b1;
        1: DO_READY = pat[cyc % 6];
        default: DO_READY = 1'($urandom);
      endcase
      stall = DO_VALID && !DO_READY;
      prev = DO;
      if (DO_VALID && DO_READY) begin
        n_checks++;
        if (DO !== exp_q[0]) begin
          n_fail++;
          $display("FAIL word%0d: got %h need %h",
                   acc, DO, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acc++;
      end
      tick();
      cyc++;
      if (acc == eff) break;
    end
    START = 1'b0;
    LD_EN = 1'b0;
    n_checks++;
    if (acc != eff) begin
      n_fail++;
      $display("FAIL timeout: got %0d words need %0d",
               acc, eff);
    end else if (DONE !== 1'b1 || BUSY !== 1'b0 ||
                 DO_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL done: done=%b busy=%b v=%b need 1 0 0",
               DONE, BUSY, DO_VALID);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    n_checks++;
    if (DO !== '0 || DO_VALID !== 1'b0 || BUSY !== 1'b0 ||
        DONE !== 1'b0 || LD_DROP !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: do=%h v=%b b=%b d=%b dr=%b",
               DO, DO_VALID, BUSY, DONE, LD_DROP);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_full_stream();
    for (int i = 0; i < DEPTH; i++)
      load_word(DW'(3 * i + 1));
    run_stream(0, 28, 0, -1, -1, 0, '0, 1);
  endtask

  task automatic test_wrap();
    run_stream(26, 4, 0, -1, -1, 0, '0, 1);
  endtask

  task automatic test_backpressure();
    run_stream(AW'($urandom_range(0, 27)), 6,
               1, -1, -1, 0, '0, 0);
  endtask

  task automatic test_ld_conflict();
    run_stream(AW'($urandom_range(0, 27)), 10,
               0, 3, -1, 0, '0, 0);
    run_stream(0, 0, 2, -1, -1, 0, '0, 0);
  endtask

  task automatic test_start_conflict();
    run_stream(AW'($urandom_range(0, 27)), 8,
               2, -1, 4, 0, '0, 0);
  endtask

  task automatic test_len_edges();
    run_stream(5, 0, 0, -1, -1, 0, '0, 1);
    run_stream(AW'($urandom_range(28, 31)),
               (AW+1)'($urandom_range(29, 63)),
               2, -1, -1, 0, '0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_stream(AW'($urandom_range(0, 31)), 1,
                 0, -1, -1, 0, '0, 1);
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] v;
    v = 16'hABCD;
    run_stream(0, 1, 0, -1, -1, 1, v, 1);
    n_checks++;
    if (mem_m[0] !== v || ptr_m != 1) begin
      n_fail++;
      $display("FAIL same_cycle_setup: ptr=%0d", ptr_m);
    end
  endtask

  task automatic test_random();
    int n;
    n = $urandom_range(5, 40);
    for (int i = 0; i < n; i++)
      load_word(DW'($urandom));
    for (int i = 0; i < 6; i++)
      run_stream(AW'($urandom), (AW+1)'($urandom),
                 2, -1, -1, 0, '0, 0);
  endtask

  task automatic test_reset_midstream();
    int acc;
    int cyc;
    logic [DW-1:0] exp_w;
    acc = 0;
    cyc = 0;
    START = 1'b1;
    START_ADDR = 0;
    LEN = 10;
    tick();
    START = 1'b0;
    DO_READY = 1'b1;
    while (acc < 3 && cyc < 50) begin
      if (DO_VALID) begin
        exp_w = mem_m[acc];
        n_checks++;
        if (DO !== exp_w) begin
          n_fail++;
          $display("FAIL rst_word%0d: got %h need %h",
                   acc, DO, exp_w);
        end
        acc++;
      end
      tick();
      cyc++;
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (DO_VALID !== 1'b0 || BUSY !== 1'b0 ||
        DONE !== 1'b0 || DO !== '0) begin
      n_fail++;
      $display("FAIL async_rst: v=%b b=%b d=%b do=%h",
               DO_VALID, BUSY, DONE, DO);
    end
    tick();
    RST = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 ||
          DO_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst: d=%b b=%b v=%b need 0 0 0",
                 DONE, BUSY, DO_VALID);
      end
    end
    run_stream(0, 0, 2, -1, -1, 0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_wrap();
    test_backpressure();
    test_ld_conflict();
    test_start_conflict();
    test_len_edges();
    test_back_to_back();
    test_same_cycle();
    test_random();
    test_reset_midstream();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
